// File: rtl/multichannel_period_counter.sv
// multichannel_period_counter
//
// Measures NUM_CH asynchronous inputs. In frequency mode (mode = 0) it counts
// rising edges per GATE_CYCLES-long window. In period mode (mode = 1) it counts
// clock cycles between consecutive rising edges. Each channel has its own
// synchroniser, edge detector, saturating accumulator and sticky
// data_ready / overrun / saturated flags, with a per-channel ack.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-high clear of all state
//   sig_in     [NUM_CH]        asynchronous measured inputs
//   enable     1 = measure, 0 = idle (accumulators cleared, results held)
//   mode       0 = frequency, 1 = period (all channels)
//   ack        [NUM_CH]        consumes the channel's pending result
//   result     [NUM_CH*CNT_W]  latched results, channel c at [c*CNT_W +: CNT_W]
//   data_ready [NUM_CH]        sticky new-result flag
//   overrun    [NUM_CH]        a result was overwritten before ack
//   saturated  [NUM_CH]        the current result clipped at all-ones
//   rd_sel     readback channel select
//   rd_result  combinational readback of result[rd_sel], 0 when out of range
module multichannel_period_counter #(
   parameter int NUM_CH      = 2,
   parameter int CNT_W       = 32,
   parameter int GATE_CYCLES = 100_000_000,
   localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_CH-1:0]         sig_in,
   input  logic                      enable,
   input  logic                      mode,
   input  logic [NUM_CH-1:0]         ack,
   output logic [NUM_CH*CNT_W-1:0]   result,
   output logic [NUM_CH-1:0]         data_ready,
   output logic [NUM_CH-1:0]         overrun,
   output logic [NUM_CH-1:0]         saturated,
   input  logic [SEL_W-1:0]          rd_sel,
   output logic [CNT_W-1:0]          rd_result
);

   localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [GATE_W-1:0] GATE_ONE  = GATE_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_MEASURE = 1'b1;

   logic [NUM_CH-1:0] sync1_r;
   logic [NUM_CH-1:0] sync2_r;
   logic [NUM_CH-1:0] sync3_r;
   logic [NUM_CH-1:0] edge_s;
   logic              mode_r;
   logic              restart_s;
   logic [GATE_W-1:0] gate_cnt_r;
   logic              gate_term_s;
   logic [NUM_CH-1:0] state_r;
   logic [CNT_W-1:0]  acc_r        [NUM_CH];
   logic [CNT_W-1:0]  acc_inc_s    [NUM_CH];
   logic [CNT_W-1:0]  new_result_s [NUM_CH];
   logic [NUM_CH-1:0] evt_s;

   assign edge_s      = sync2_r & ~sync3_r;
   // Disabling or flipping mode throws away the partial measurement.
   assign restart_s   = ~enable | (mode ^ mode_r);
   assign gate_term_s = (gate_cnt_r == GATE_LAST);

   // Two-flop synchroniser plus a third flop for rising-edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_r <= {NUM_CH{1'b0}};
         sync2_r <= {NUM_CH{1'b0}};
         sync3_r <= {NUM_CH{1'b0}};
      end else begin
         sync1_r <= sig_in;
         sync2_r <= sync1_r;
         sync3_r <= sync2_r;
      end
   end

   // Previous mode, used to detect a mode change.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_r <= 1'b0;
      end else begin
         mode_r <= mode;
      end
   end

   // Shared gate counter; windows are contiguous, parked at 0 outside frequency mode.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gate_cnt_r <= {GATE_W{1'b0}};
      end else if (restart_s || mode) begin
         gate_cnt_r <= {GATE_W{1'b0}};
      end else if (gate_term_s) begin
         gate_cnt_r <= {GATE_W{1'b0}};
      end else begin
         gate_cnt_r <= gate_cnt_r + GATE_ONE;
      end
   end

   // Per-channel saturating increment, result-event decode and value to latch.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         acc_inc_s[c]    = (acc_r[c] == CNT_MAX) ? CNT_MAX : (acc_r[c] + CNT_ONE);
         evt_s[c]        = 1'b0;
         new_result_s[c] = acc_r[c];
         if (restart_s) begin
            evt_s[c]        = 1'b0;
            new_result_s[c] = acc_r[c];
         end else if (mode == 1'b0) begin
            // An edge in the terminal cycle still belongs to this window.
            evt_s[c]        = gate_term_s;
            new_result_s[c] = edge_s[c] ? acc_inc_s[c] : acc_r[c];
         end else begin
            evt_s[c]        = (state_r[c] == ST_MEASURE) & edge_s[c];
            new_result_s[c] = acc_r[c];
         end
      end
   end

   // Accumulators, period FSMs, latched results and handshake flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result     <= {(NUM_CH*CNT_W){1'b0}};
         data_ready <= {NUM_CH{1'b0}};
         overrun    <= {NUM_CH{1'b0}};
         saturated  <= {NUM_CH{1'b0}};
         state_r    <= {NUM_CH{1'b0}};
         for (int c = 0; c < NUM_CH; c++) begin
            acc_r[c] <= {CNT_W{1'b0}};
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (restart_s) begin
               acc_r[c]   <= {CNT_W{1'b0}};
               state_r[c] <= ST_IDLE;
            end else if (mode == 1'b0) begin
               state_r[c] <= ST_IDLE;
               if (gate_term_s) begin
                  acc_r[c] <= {CNT_W{1'b0}};
               end else if (edge_s[c]) begin
                  acc_r[c] <= acc_inc_s[c];
               end else begin
                  acc_r[c] <= acc_r[c];
               end
            end else begin
               case (state_r[c])
                  ST_IDLE: begin
                     // First edge only arms the measurement.
                     if (edge_s[c]) begin
                        acc_r[c]   <= CNT_ONE;
                        state_r[c] <= ST_MEASURE;
                     end else begin
                        acc_r[c]   <= {CNT_W{1'b0}};
                        state_r[c] <= ST_IDLE;
                     end
                  end
                  ST_MEASURE: begin
                     // The edge cycle itself counts as 1 of the next period.
                     if (edge_s[c]) begin
                        acc_r[c] <= CNT_ONE;
                     end else begin
                        acc_r[c] <= acc_inc_s[c];
                     end
                     state_r[c] <= ST_MEASURE;
                  end
                  default: begin
                     acc_r[c]   <= {CNT_W{1'b0}};
                     state_r[c] <= ST_IDLE;
                  end
               endcase
            end

            // A new result wins over a coincident ack.
            if (evt_s[c]) begin
               result[c*CNT_W +: CNT_W] <= new_result_s[c];
               saturated[c]             <= (new_result_s[c] == CNT_MAX);
               data_ready[c]            <= 1'b1;
               overrun[c]               <= data_ready[c] & ~ack[c];
            end else if (ack[c]) begin
               data_ready[c] <= 1'b0;
               overrun[c]    <= 1'b0;
            end
         end
      end
   end

   // Readback mux; an out-of-range select matches no channel and reads 0.
   always_comb begin
      rd_result = {CNT_W{1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
         rd_result = rd_result
                   | ({CNT_W{rd_sel == SEL_W'(c)}} & result[c*CNT_W +: CNT_W]);
      end
   end

endmodule

// File: tb/tb_multichannel_period_counter.sv
module tb_multichannel_period_counter;

   localparam int NUM_CH = 3;
   localparam int CNT_W  = 8;
   localparam int GATE   = 100;
   localparam int SEL_W  = 2;
   localparam int MAXC   = 16384;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [NUM_CH-1:0]       sig_in;
   logic                    enable;
   logic                    mode;
   logic [NUM_CH-1:0]       ack;
   logic [NUM_CH*CNT_W-1:0] result;
   logic [NUM_CH-1:0]       data_ready;
   logic [NUM_CH-1:0]       overrun;
   logic [NUM_CH-1:0]       saturated;
   logic [SEL_W-1:0]        rd_sel;
   logic [CNT_W-1:0]        rd_result;

   always #5 clk = ~clk;

   multichannel_period_counter #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .GATE_CYCLES(GATE)
   ) dut (
      .clk(clk), .reset(reset), .sig_in(sig_in), .enable(enable), .mode(mode),
      .ack(ack), .result(result), .data_ready(data_ready), .overrun(overrun),
      .saturated(saturated), .rd_sel(rd_sel), .rd_result(rd_result)
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   typedef struct {
      int                      n;
      logic [NUM_CH*CNT_W-1:0] res;
      logic [NUM_CH-1:0]       dr;
      logic [NUM_CH-1:0]       ov;
      logic [NUM_CH-1:0]       sat;
      logic [CNT_W-1:0]        rd;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   // ---------------- reference model (event/time based) ----------------
   logic [NUM_CH-1:0] in_hist   [MAXC];
   logic [NUM_CH-1:0] edge_hist [MAXC];
   int   m_base, m_win_start;
   int   m_last   [NUM_CH];
   int   m_result [NUM_CH];
   bit   m_prev_active, m_mode_prev;
   logic [NUM_CH-1:0] m_dr, m_ov, m_sat;
   bit   p_active;
   logic [NUM_CH-1:0] p_edge, p_evt;
   int   p_val [NUM_CH];

   function automatic logic in_at(input int k, input int c);
      return (k <= m_base) ? 1'b0 : in_hist[k][c];
   endfunction

   function automatic void model_reset();
      m_base = cyc;
      m_win_start = 0;
      m_prev_active = 1'b0;
      m_mode_prev = 1'b0;
      m_dr = '0; m_ov = '0; m_sat = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         m_last[c] = -1;
         m_result[c] = 0;
      end
   endfunction

   // What happens at clock edge n: a channel sees an edge when the input was
   // sampled low three edges ago and high two edges ago.
   function automatic void predict(input int n, input logic en, input logic md);
      int ws, cnt;
      p_active = en && (md == m_mode_prev);
      ws = m_prev_active ? m_win_start : n;
      for (int c = 0; c < NUM_CH; c++) begin
         p_edge[c] = in_at(n - 2, c) & ~in_at(n - 3, c);
         p_evt[c] = 1'b0;
         p_val[c] = 0;
         if (p_active) begin
            if (md == 1'b0) begin
               if (((n - ws) % GATE) == GATE - 1) begin
                  cnt = p_edge[c] ? 1 : 0;
                  for (int k = n - GATE + 1; k < n; k++) cnt += edge_hist[k][c] ? 1 : 0;
                  p_evt[c] = 1'b1;
                  p_val[c] = cnt;
               end
            end else if (p_edge[c] && m_last[c] >= 0) begin
               p_evt[c] = 1'b1;
               p_val[c] = n - m_last[c];
            end
         end
      end
   endfunction

   function automatic void apply(input int n, input logic [NUM_CH-1:0] sig, input logic en,
                                 input logic md, input logic [NUM_CH-1:0] a,
                                 input logic [SEL_W-1:0] rs);
      exp_t e;
      predict(n, en, md);
      in_hist[n] = sig;
      edge_hist[n] = p_active ? p_edge : '0;
      if (p_active) begin
         if (!m_prev_active) m_win_start = n;
         m_prev_active = 1'b1;
         if (md) begin
            for (int c = 0; c < NUM_CH; c++) if (p_edge[c]) m_last[c] = n;
         end
      end else begin
         m_prev_active = 1'b0;
         for (int c = 0; c < NUM_CH; c++) m_last[c] = -1;
      end
      m_mode_prev = md;
      for (int c = 0; c < NUM_CH; c++) begin
         if (p_evt[c]) begin
            m_ov[c] = m_dr[c] & ~a[c];
            m_dr[c] = 1'b1;
            m_result[c] = (p_val[c] > CMAX) ? CMAX : p_val[c];
            m_sat[c] = (p_val[c] >= CMAX);
         end else if (a[c]) begin
            m_dr[c] = 1'b0;
            m_ov[c] = 1'b0;
         end
      end
      e.n = n;
      e.res = '0;
      for (int c = 0; c < NUM_CH; c++) e.res[c*CNT_W +: CNT_W] = m_result[c][CNT_W-1:0];
      e.dr = m_dr; e.ov = m_ov; e.sat = m_sat;
      e.rd = (int'(rs) < NUM_CH) ? m_result[rs][CNT_W-1:0] : '0;
      exp_q.push_back(e);
   endfunction

   // ---------------- monitor ----------------
   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         vectors++;
         if (result !== mon_e.res || data_ready !== mon_e.dr || overrun !== mon_e.ov ||
             saturated !== mon_e.sat || rd_result !== mon_e.rd) begin
            miscompares++;
            $display("FAIL outputs@cycle%0d: result=%h dr=%b ov=%b sat=%b rd=%h, expected result=%h dr=%b ov=%b sat=%b rd=%h",
                     mon_e.n, result, data_ready, overrun, saturated, rd_result,
                     mon_e.res, mon_e.dr, mon_e.ov, mon_e.sat, mon_e.rd);
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- stimulus ----------------
   int   g_hi [NUM_CH];
   int   g_lo [NUM_CH];
   int   g_cnt[NUM_CH];
   bit   g_rand[NUM_CH];
   logic [NUM_CH-1:0] g_lvl = '0;
   bit   en_v, md_v, rd_rand;
   int   ack_mode;
   logic [SEL_W-1:0] rd_fix;

   function automatic void gen_set(input int c, input int hi, input int lo, input bit rnd);
      g_hi[c] = hi; g_lo[c] = lo; g_rand[c] = rnd;
      g_lvl[c] = 1'b0; g_cnt[c] = lo;
   endfunction

   function automatic void gen_step();
      for (int c = 0; c < NUM_CH; c++) begin
         g_cnt[c]--;
         if (g_cnt[c] <= 0) begin
            g_lvl[c] = ~g_lvl[c];
            if (g_rand[c]) g_cnt[c] = int'($urandom_range(2, 14));
            else g_cnt[c] = g_lvl[c] ? g_hi[c] : g_lo[c];
         end
      end
   endfunction

   // Drive one cycle from a negedge, predict the next edge, end at the next negedge.
   task automatic cycle(input logic [NUM_CH-1:0] a);
      int n;
      n = cyc + 1;
      if (n >= MAXC) begin
         $display("FAIL cycle_budget: got %0d, expected below %0d", n, MAXC);
         $fatal(1);
      end
      gen_step();
      sig_in = g_lvl; ack = a; enable = en_v; mode = md_v;
      rd_sel = rd_rand ? SEL_W'($urandom_range(0, 3)) : rd_fix;
      if (!reset) apply(n, g_lvl, en_v, md_v, a, rd_sel);
      @(posedge clk);
      cyc = n;
      @(negedge clk);
   endtask

   task automatic run(input int k);
      logic [NUM_CH-1:0] a;
      for (int i = 0; i < k; i++) begin
         a = '0;
         if (ack_mode == 1) for (int c = 0; c < NUM_CH; c++) a[c] = ($urandom_range(0, 5) == 0);
         cycle(a);
      end
   endtask

   task automatic clock_in_reset(input int k);
      for (int i = 0; i < k; i++) begin
         @(posedge clk);
         cyc++;
      end
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit done;
      reset = 1'b1; sig_in = '0; enable = 1'b0; mode = 1'b0; ack = '0; rd_sel = '0;
      en_v = 1'b0; md_v = 1'b0; ack_mode = 0; rd_rand = 1'b1; rd_fix = '0;
      gen_set(0, 5, 5, 1'b0);
      gen_set(1, 12, 13, 1'b0);
      gen_set(2, 3, 3, 1'b1);
      #1;
      check("reset_result", result, 0);
      check("reset_dr", data_ready, 0);
      check("reset_ov", overrun, 0);
      check("reset_sat", saturated, 0);
      check("reset_rd", rd_result, 0);
      clock_in_reset(2);
      reset = 1'b0;
      model_reset();

      // Frequency mode.
      en_v = 1'b1; md_v = 1'b0;
      run(350);
      check("freq_ch0_10", result[0*CNT_W +: CNT_W], 10);
      check("freq_ch1_4", result[1*CNT_W +: CNT_W], 4);
      check("freq_dr_all", data_ready, 3'b111);
      ack_mode = 1;
      run(150);

      // Asynchronous reset in cycle 40 of a window, between clock edges.
      ack_mode = 0;
      for (int i = 0; i < GATE && ((cyc - m_win_start) % GATE) != 40; i++) cycle('0);
      reset = 1'b1;
      #1;
      check("midreset_result", result, 0);
      check("midreset_dr", data_ready, 0);
      check("midreset_ov", overrun, 0);
      check("midreset_sat", saturated, 0);
      check("midreset_rd", rd_result, 0);
      clock_in_reset(2);
      reset = 1'b0;
      model_reset();
      run(99);
      check("postreset_dr_99", data_ready, 3'b000);
      run(1);
      check("postreset_dr_100", data_ready, 3'b111);

      // Mode switch mid-window to period mode.
      run(50);
      cycle(3'b111);
      md_v = 1'b1;
      gen_set(0, 10, 27, 1'b0);
      gen_set(1, 150, 150, 1'b0);
      gen_set(2, 8, 8, 1'b0);
      run(20);
      check("modesw_dr_held", data_ready[1:0], 2'b00);
      run(250);
      check("period_ch0_37", result[0*CNT_W +: CNT_W], 37);
      check("overrun_set", overrun[0], 1);

      // Ack on a cycle without a result clears both flags.
      done = 1'b0;
      for (int i = 0; i < 50 && !done; i++) begin
         predict(cyc + 1, en_v, md_v);
         if (p_evt[0] == 1'b0) begin
            cycle(3'b001);
            done = 1'b1;
         end else cycle('0);
      end
      check("ack_found", done, 1);
      check("ack_dr_clear", data_ready[0], 0);
      check("ack_ov_clear", overrun[0], 0);

      // Ack coincident with a new result while one is already pending.
      for (int i = 0; i < 100 && m_dr[0] == 1'b0; i++) cycle('0);
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         predict(cyc + 1, en_v, md_v);
         if (p_evt[0]) begin
            cycle(3'b001);
            done = 1'b1;
         end else cycle('0);
      end
      check("coinc_found", done, 1);
      check("coinc_dr", data_ready[0], 1);
      check("coinc_ov", overrun[0], 0);

      // Saturation on 300-cycle periods, then recovery at 50.
      run(700);
      check("sat_ch1_255", result[1*CNT_W +: CNT_W], 255);
      check("sat_ch1_flag", saturated[1], 1);
      rd_rand = 1'b0; rd_fix = 2'd0;
      cycle('0);
      check("rd_sel0_37", rd_result, 37);
      rd_fix = 2'd3;
      cycle('0);
      check("rd_sel3_zero", rd_result, 0);
      rd_rand = 1'b1;
      gen_set(1, 25, 25, 1'b0);
      run(300);
      check("unsat_ch1_50", result[1*CNT_W +: CNT_W], 50);
      check("unsat_ch1_flag", saturated[1], 0);

      // Disable: results held, ack still clears data_ready.
      run(40);
      en_v = 1'b0;
      run(20);
      check("dis_ch0_held", result[0*CNT_W +: CNT_W], 37);
      check("dis_ch1_held", result[1*CNT_W +: CNT_W], 50);
      check("dis_dr_held", data_ready[1:0], 2'b11);
      cycle(3'b011);
      check("dis_ack_clears", data_ready[1:0], 2'b00);
      run(20);
      check("dis_ch0_still", result[0*CNT_W +: CNT_W], 37);

      // Randomised traffic with mode and enable changes.
      gen_set(0, 2, 2, 1'b1);
      gen_set(1, 2, 2, 1'b1);
      gen_set(2, 2, 2, 1'b1);
      ack_mode = 1;
      for (int b = 0; b < 10; b++) begin
         en_v = ($urandom_range(0, 5) != 0);
         md_v = $urandom_range(0, 1);
         run(150);
      end
      run(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
